sort4_signed_ctrl: RTL and testbench
====================================

SORT4_SIGNED_CTRL -- requirements
Module: sort4_signed_ctrl

Interface
REQ-001 Parameter SORT_DESC, default 0, order select: 0 = ascending, 1 = descending (signed two's-complement order).
REQ-002 clk  input  1  rising-edge system clock; single clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a sort job; sampled only in IDLE.
REQ-005 din  input  3  operand, 3-bit two's complement, bit 2 = sign/MSB (range -4..+3).
REQ-006 din_valid  input  1  din holds a valid operand.
REQ-007 din_ready  output  1  high exactly when state = LOAD.
REQ-008 dout  output  3  current sorted result element, same encoding as din.
REQ-009 dout_valid  output  1  high exactly when state = OUT.
REQ-010 dout_ready  input  1  consumer accepts dout.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse after the 4th result is accepted.
REQ-013 swap_count  output  3  number of swaps performed in the last or current job (0..6).

Function
REQ-014 FSM states IDLE, LOAD, SORT, OUT; one state transition per clk at most.
REQ-015 IDLE: start=1 -> LOAD next cycle; clear ld_idx, pass/idx counters and swap_count; register file r[0..3] retains contents.
REQ-016 LOAD: each cycle with din_valid=1 -> r[ld_idx] <= din, ld_idx++; cycles with din_valid=0 are stalls with no change.
REQ-017 LOAD: acceptance of the 4th operand (ld_idx=3) -> SORT next cycle.
REQ-018 SORT: one signed compare-and-swap per cycle over a single shared comparator; bubble order pass p=0..2, index i=0..2, compare r[i] with r[i+1]; exactly 9 SORT cycles, no early exit.
REQ-019 Compare semantics: signed 3-bit; produces E/L/G with exactly one asserted; -4 < -1 < 0 < 3.
REQ-020 Swap when G (SORT_DESC=0) or L (SORT_DESC=1); never swap on E (stable); swap_count increments on each swap.
REQ-021 After the 9th compare -> OUT; out_idx=0.
REQ-022 OUT: dout = r[out_idx]; the handshake completes when dout_valid & dout_ready, then out_idx++; dout_ready=0 holds dout stable.
REQ-023 OUT: handshake at out_idx=3 -> IDLE next cycle, with done=1 for exactly that first IDLE cycle.
REQ-024 start ignored outside IDLE; din_valid ignored outside LOAD; dout_ready ignored outside OUT.
REQ-025 Minimum latency: with continuous valid/ready, start at cycle 0 -> din_ready cycles 1-4, SORT cycles 5-13, dout_valid cycles 14-17, done cycle 18.
REQ-026 start asserted in the same cycle as done: accepted; state IDLE -> LOAD.
REQ-027 swap_count holds its final value through IDLE until the next start.

Reset
REQ-028 reset=1 at any time, including mid-LOAD, SORT or OUT -> immediately: state IDLE, r[0..3]=0, all counters 0, din_ready=0, dout_valid=0, busy=0, done=0, swap_count=0, dout=0.
REQ-029 After reset deasserts, the first start is honoured on the next rising edge; the aborted job produces no done.

Verification
REQ-030 SORT_DESC=0, load 3,-4,0,-1 (011,100,000,111) -> dout -4,-1,0,3 (100,111,000,011); swap_count=4; done once.
REQ-031 Load 3,2,-1,-4 -> dout -4,-1,2,3; swap_count=6. Load -4,-2,1,3 -> swap_count=0, order unchanged.
REQ-032 Load -2,-2,-2,-2 -> four dout values of 110; swap_count=0 (no swap on E).
REQ-033 SORT_DESC=1, load -4,3,0,-1 -> dout 3,0,-1,-4.
REQ-034 Hold dout_ready=0 for 5 cycles in OUT -> dout/dout_valid stable; din_valid gaps in LOAD -> correct capture; start pulsed during SORT -> ignored.
REQ-035 Assert reset during SORT cycle 4 -> all outputs 0 immediately; a new job afterward sorts correctly with no stale data and no done for the aborted job.

Source files
------------

// File: rtl/sort4_signed_ctrl.sv
// Four-entry signed bubble sorter: load four 3-bit operands, sort them with a single
// shared compare-and-swap unit over nine fixed cycles, then stream them out.
module sort4_signed_ctrl #(
    parameter int SORT_DESC = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] swap_count
);

    localparam int DATA_W = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SORT = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]               state;
    logic signed [DATA_W-1:0] r [0:3];
    logic [1:0]               ld_idx;
    logic [1:0]               pass_idx;
    logic [1:0]               cmp_idx;
    logic [1:0]               cmp_nxt;
    logic [1:0]               out_idx;
    logic [2:0]               swap_cnt;
    logic                     done_q;

    logic signed [DATA_W-1:0] cmp_a;
    logic signed [DATA_W-1:0] cmp_b;
    logic [2:0]               cmp_leg;
    logic                     do_swap;
    logic                     sort_last;
    logic                     load_fire;
    logic                     out_fire;

    // Result is {lt, eq, gt}; exactly one bit is set for any operand pair.
    function automatic logic [2:0] cmp_signed(input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
        logic [2:0] leg;
        leg = 3'b000;
        if (a < b)
            leg = 3'b100;
        else if (a == b)
            leg = 3'b010;
        else
            leg = 3'b001;
        return leg;
    endfunction

    // Equal operands never swap, which keeps the sort stable.
    function automatic logic swap_needed(input logic [2:0] leg);
        logic sw;
        if (SORT_DESC != 0)
            sw = leg[2];
        else
            sw = leg[0];
        return sw;
    endfunction

    always_comb begin
        cmp_nxt   = cmp_idx + 2'd1;
        cmp_a     = r[cmp_idx];
        cmp_b     = r[cmp_nxt];
        cmp_leg   = cmp_signed(cmp_a, cmp_b);
        do_swap   = (state == SORT) && swap_needed(cmp_leg);
        sort_last = (pass_idx == 2'd2) && (cmp_idx == 2'd2);
        load_fire = (state == LOAD) && din_valid;
        out_fire  = (state == OUT) && dout_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ld_idx   <= 2'd0;
            pass_idx <= 2'd0;
            cmp_idx  <= 2'd0;
            out_idx  <= 2'd0;
            swap_cnt <= 3'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        ld_idx   <= 2'd0;
                        pass_idx <= 2'd0;
                        cmp_idx  <= 2'd0;
                        out_idx  <= 2'd0;
                        swap_cnt <= 3'd0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        ld_idx <= ld_idx + 2'd1;
                        if (ld_idx == 2'd3)
                            state <= SORT;
                    end
                end
                SORT: begin
                    if (do_swap)
                        swap_cnt <= swap_cnt + 3'd1;
                    if (cmp_idx == 2'd2) begin
                        cmp_idx  <= 2'd0;
                        pass_idx <= pass_idx + 2'd1;
                    end else begin
                        cmp_idx <= cmp_nxt;
                    end
                    if (sort_last) begin
                        state    <= OUT;
                        pass_idx <= 2'd0;
                        out_idx  <= 2'd0;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        out_idx <= out_idx + 2'd1;
                        if (out_idx == 2'd3) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file: written by operand capture and by the compare-and-swap unit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++)
                r[k] <= '0;
        end else if (load_fire) begin
            r[ld_idx] <= din;
        end else if (do_swap) begin
            r[cmp_idx] <= cmp_b;
            r[cmp_nxt] <= cmp_a;
        end
    end

    assign din_ready  = (state == LOAD);
    assign dout_valid = (state == OUT);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign swap_count = swap_cnt;
    assign dout       = r[out_idx];

endmodule

// File: tb/tb_sort4_signed_ctrl.sv
// Scoreboard bench for sort4_signed_ctrl: ascending and descending instances share stimulus.
module tb_sort4_signed_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] din;
    logic       din_valid;
    logic       dout_ready;

    logic       din_ready_a, dout_valid_a, busy_a, done_a;
    logic [2:0] dout_a, swap_count_a;
    logic       din_ready_d, dout_valid_d, busy_d, done_d;
    logic [2:0] dout_d, swap_count_d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_d = 0;
    int jobs_run = 0;
    logic [2:0] q_a[$];
    logic [2:0] q_d[$];
    logic [2:0] e_a, e_d;

    sort4_signed_ctrl #(.SORT_DESC(0)) u_asc (
        .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_a), .dout(dout_a), .dout_valid(dout_valid_a),
        .dout_ready(dout_ready), .busy(busy_a), .done(done_a), .swap_count(swap_count_a)
    );

    sort4_signed_ctrl #(.SORT_DESC(1)) u_desc (
        .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_d), .dout(dout_d), .dout_valid(dout_valid_d),
        .dout_ready(dout_ready), .busy(busy_d), .done(done_d), .swap_count(swap_count_d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_d) done_cnt_d++;
        if (!reset && dout_valid_a && dout_ready) begin
            if (q_a.size() == 0) chk("asc_unexpected_out", 1, 0);
            else begin
                e_a = q_a.pop_front();
                chk("asc_dout", dout_a, e_a);
            end
        end
        if (!reset && dout_valid_d && dout_ready) begin
            if (q_d.size() == 0) chk("desc_unexpected_out", 1, 0);
            else begin
                e_d = q_d.pop_front();
                chk("desc_dout", dout_d, e_d);
            end
        end
    end

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        logic [2:0] x0, x1, x2, x3;
        x0 = a[2:0]; x1 = b[2:0]; x2 = c[2:0]; x3 = d[2:0];
        return {x3, x2, x1, x0};
    endfunction

    // Reference: plain bubble sort on signed values, counting swaps.
    function automatic int model_sort(input logic [11:0] vin, input bit desc,
                                      output logic [11:0] vout);
        logic signed [2:0] a[4];
        logic signed [2:0] t;
        int sw;
        sw = 0;
        for (int k = 0; k < 4; k++) a[k] = vin[3*k +: 3];
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 3; i++)
                if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw++;
                end
        vout = {a[3], a[2], a[1], a[0]};
        return sw;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [11:0] vec, input bit gaps, input bit stall,
                           input bit pulse, input bit b2b);
        logic [11:0] sa, sd;
        int swa, swd, n, t0;
        logic [2:0] d0;
        swa = model_sort(vec, 1'b0, sa);
        swd = model_sort(vec, 1'b1, sd);
        for (int k = 0; k < 4; k++) begin
            q_a.push_back(sa[3*k +: 3]);
            q_d.push_back(sd[3*k +: 3]);
        end
        jobs_run++;
        dout_ready = !stall;
        t0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_ready", din_ready_a, 1);
        chk("load_busy", busy_a, 1);
        for (int k = 0; k < 4; k++) begin
            if (gaps && (k % 2 == 1)) begin
                din_valid = 1'b0;
                din = 3'b101;
                tick();
            end
            din = vec[3*k +: 3];
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        chk("sort_not_ready", din_ready_a, 0);
        n = 0;
        while (!dout_valid_a && n < 30) begin
            start = pulse && (n == 3);
            tick();
            start = 1'b0;
            n++;
        end
        chk("sort_cycles", n, 9);
        if (stall) begin
            d0 = dout_a;
            repeat (5) begin
                tick();
                chk("stall_dout", dout_a, d0);
                chk("stall_valid", dout_valid_a, 1);
            end
            dout_ready = 1'b1;
        end
        n = 0;
        while (dout_valid_a && n < 10) begin
            tick();
            n++;
        end
        chk("out_cycles", n, 4);
        chk("done_asc", done_a, 1);
        chk("done_desc", done_d, 1);
        chk("idle_busy", busy_a, 0);
        chk("swaps_asc", swap_count_a, swa);
        chk("swaps_desc", swap_count_d, swd);
        if (!gaps && !stall) chk("latency", cyc - t0, 18);
        if (!b2b) begin
            tick();
            chk("done_clear", done_a, 0);
            chk("swaps_hold", swap_count_a, swa);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_din_ready", din_ready_a, 0);
        chk("rst_dout_valid", dout_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_swaps", swap_count_a, 0);
        chk("rst_dout", dout_a, 0);
        chk("rst_busy_d", busy_d, 0);
        chk("rst_swaps_d", swap_count_d, 0);
        chk("rst_dout_d", dout_d, 0);
    endtask

    task automatic abort_then_recover();
        int dc;
        dc = done_cnt_a;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din = 3'(k + 1);
            din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        repeat (3) tick();
        chk("abort_in_sort", busy_a && !din_ready_a && !dout_valid_a, 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        tick();
        reset = 1'b0;
        run_job(pk(1, -3, 2, -2), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_no_done", done_cnt_a, dc + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        din = 3'b000;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        reset = 1'b0;
        tick();

        run_job(pk(3, -4, 0, -1), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("spec_swaps_4", swap_count_a, 4);
        run_job(pk(3, 2, -1, -4), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("spec_swaps_6", swap_count_a, 6);
        run_job(pk(-4, -2, 1, 3), 1'b0, 1'b1, 1'b0, 1'b0);
        chk("spec_swaps_0", swap_count_a, 0);
        run_job(pk(-2, -2, -2, -2), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("equal_swaps", swap_count_a, 0);
        chk("equal_swaps_d", swap_count_d, 0);
        run_job(pk(-4, 3, 0, -1), 1'b0, 1'b0, 1'b1, 1'b0);

        abort_then_recover();

        for (int j = 0; j < 6; j++) begin
            run_job(12'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (2) tick();
        chk("q_asc_empty", q_a.size(), 0);
        chk("q_desc_empty", q_d.size(), 0);
        chk("done_count_asc", done_cnt_a, jobs_run);
        chk("done_count_desc", done_cnt_d, jobs_run);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
